// File: rtl/uart_tx_fifo_reader.sv
// TX FIFO read-side consumer: pops one byte per frame and serialises it as 8N1 UART, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo_reader #(
  parameter int unsigned W_DATA       = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              i_rd_clk,
  input  logic              i_rd_rstn,
  input  logic              i_tx_en,
  input  logic              i_fifo_empty,
  input  logic [W_DATA-1:0] i_RDATA,
  output logic              o_rd_en,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_byte_done,
  output logic [CNT_W-1:0]  o_tx_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (W_DATA > 1) ? $clog2(W_DATA) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_n;
  logic [BAUD_W-1:0]   baud_q, baud_n;
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [W_DATA-1:0]   shift_q, shift_n;
  logic                bit_end;
  logic                timed;
  logic                tx_n;
  logic                rd_en_n;
  logic                busy_n;
  logic                done_n;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_n;
`endif

  // State register plus registered outputs, all derived from next-state values
  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      o_tx        <= 1'b1;
      o_rd_en     <= 1'b0;
      o_busy      <= 1'b0;
      o_byte_done <= 1'b0;
      o_tx_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      baud_q      <= baud_n;
      bit_q       <= bit_n;
      shift_q     <= shift_n;
      o_tx        <= tx_n;
      o_rd_en     <= rd_en_n;
      o_busy      <= busy_n;
      o_byte_done <= done_n;
      if (done_n) begin
        o_tx_cnt <= o_tx_cnt + CNT_W'(1);
      end
`ifdef UART_TX_PARITY_EN
      par_q       <= par_n;
`endif
    end
  end

  // Next-state, bit timing and next output values
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = 1'b1;
    rd_en_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    bit_end = (baud_q == BAUD_LAST);
    timed   = (state_q != IDLE) && (state_q != FETCH) && (state_q != LOAD);
    if (timed) begin
      baud_n = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_tx_en && !i_fifo_empty) begin
          state_n = FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shift_n = i_RDATA;
        baud_n  = '0;
        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
        par_n   = ^i_RDATA;
`endif
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          bit_n   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
    rd_en_n = (state_n == FETCH);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == STOP) && (baud_n == BAUD_LAST);
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Self-checking bench for uart_tx_fifo_reader: FIFO model, line decoder and scoreboard of sent bytes.
// Build with UART_TX_PARITY_EN defined to also exercise the parity bit and counter wrap.
module tb_uart_tx_fifo_reader;

  localparam int unsigned W_DATA = 8;
  localparam int unsigned CPB    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned CNT_W  = 2;
  localparam int          NBITS  = W_DATA + 3;
`else
  localparam int unsigned CNT_W  = 16;
  localparam int          NBITS  = W_DATA + 2;
`endif
  localparam int FRAME   = NBITS * CPB;
  localparam int TIMEOUT = 300;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_tx_en = 1'b1;
  logic              i_fifo_empty = 1'b1;
  logic [W_DATA-1:0] i_RDATA = '0;
  logic              o_rd_en;
  logic              o_tx;
  logic              o_busy;
  logic              o_byte_done;
  logic [CNT_W-1:0]  o_tx_cnt;

  int errors = 0;
  int checks = 0;
  int rd_pulses = 0;
  int underflow = 0;
  int exp_cnt = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo_reader #(
    .W_DATA      (W_DATA),
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CNT_W)
  ) dut (
    .i_rd_clk    (clk),
    .i_rd_rstn   (rst_n),
    .i_tx_en     (i_tx_en),
    .i_fifo_empty(i_fifo_empty),
    .i_RDATA     (i_RDATA),
    .o_rd_en     (o_rd_en),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_byte_done (o_byte_done),
    .o_tx_cnt    (o_tx_cnt)
  );

  always #5 clk = ~clk;

  // FIFO with registered read: a pop in the o_rd_en cycle presents data for the next cycle
  always @(posedge clk) begin
    #2;
    if (o_rd_en === 1'b1) begin
      rd_pulses++;
      if (fifo_q.size() == 0) underflow++;
      else i_RDATA = fifo_q.pop_front();
    end
    i_fifo_empty = (fifo_q.size() == 0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic bump_cnt();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  // Waits for a start bit, then records one frame; returns decoded fields and shape flags
  task automatic grab_frame(input int drop_at, output bit found, output logic [7:0] data,
                            output logic par, output bit shape_ok, output bit done_ok,
                            output int gap);
    logic samp [FRAME];
    logic v;
    found = 0; data = '0; par = 1'b0; shape_ok = 1; done_ok = 1; gap = 0;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(negedge clk);
      if (o_tx === 1'b0) begin
        found = 1;
        break;
      end
      gap++;
    end
    if (!found) return;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) i_tx_en = 1'b0;
      samp[c] = o_tx;
      if (o_byte_done !== ((c == FRAME - 1) ? 1'b1 : 1'b0)) done_ok = 0;
    end
    for (int b = 0; b < NBITS; b++) begin
      v = samp[b * CPB];
      for (int k = 1; k < CPB; k++) if (samp[b * CPB + k] !== v) shape_ok = 0;
      if (b == 0 && v !== 1'b0) shape_ok = 0;
      if (b == NBITS - 1 && v !== 1'b1) shape_ok = 0;
      if (b >= 1 && b <= W_DATA) data[b - 1] = v;
`ifdef UART_TX_PARITY_EN
      if (b == W_DATA + 1) par = v;
`endif
    end
  endtask

  task automatic test_reset();
    int lat, gap;
    bit found, shape_ok, done_ok;
    logic [7:0] data, exp;
    logic par;
    rst_n = 1'b0;
    i_tx_en = 1'b1;
    push_byte(8'h3C);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (o_tx !== 1'b1 || o_rd_en !== 1'b0 || o_busy !== 1'b0 || o_tx_cnt !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: tx=%b rd_en=%b busy=%b cnt=%0d, want 1 0 0 0",
                 i, o_tx, o_rd_en, o_busy, o_tx_cnt);
      end
    end
    rst_n = 1'b1;
    lat = 1;
    while (o_rd_en !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL reset_release_latency: first rd_en in cycle %0d, want 2", lat);
    end
    grab_frame(-1, found, data, par, shape_ok, done_ok, gap);
    exp = exp_q.pop_front();
    bump_cnt();
    checks++;
    if (!found || data !== exp || !shape_ok || !done_ok || gap != 1) begin
      errors++;
      $display("FAIL reset_first_frame: found=%0d data=%h shape=%0d done=%0d gap=%0d, want 1 %h 1 1 1",
               found, data, shape_ok, done_ok, gap, exp);
    end
  endtask

  task automatic test_single();
    int rd0, gap;
    bit found, shape_ok, done_ok, seen;
    logic [7:0] data, exp;
    logic par;
    rd0 = rd_pulses;
    push_byte(8'hA5);
    seen = 0;
    for (int n = 0; n < TIMEOUT && !seen; n++) begin
      @(negedge clk);
      if (o_rd_en === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL single_rd_en: no o_rd_en within %0d cycles, want one pulse", TIMEOUT);
    end
    grab_frame(-1, found, data, par, shape_ok, done_ok, gap);
    exp = exp_q.pop_front();
    bump_cnt();
    checks++;
    if (!found || gap != 1) begin
      errors++;
      $display("FAIL single_start_delay: found=%0d high cycles after rd_en=%0d, want start 2 cycles after pulse (1)",
               found, gap);
    end
    checks++;
    if (data !== exp) begin
      errors++;
      $display("FAIL single_data: decoded %h, want %h", data, exp);
    end
    checks++;
    if (!shape_ok || !done_ok) begin
      errors++;
      $display("FAIL single_frame_shape: shape=%0d byte_done=%0d, want 1 1", shape_ok, done_ok);
    end
    checks++;
    if (o_tx_cnt !== CNT_W'(exp_cnt) || rd_pulses - rd0 != 1) begin
      errors++;
      $display("FAIL single_counts: cnt=%0d rd_pulses=%0d, want %0d 1", o_tx_cnt, rd_pulses - rd0, exp_cnt);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_tx !== 1'b1 || o_byte_done !== 1'b0) begin
      errors++;
      $display("FAIL single_frame_end: busy=%b tx=%b done=%b after frame, want 0 1 0", o_busy, o_tx, o_byte_done);
    end
  endtask

  task automatic test_back_to_back();
    int rd0, gap;
    bit found, shape_ok, done_ok;
    logic [7:0] data, exp;
    logic par;
    rd0 = rd_pulses;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    for (int f = 0; f < 3; f++) begin
      grab_frame(-1, found, data, par, shape_ok, done_ok, gap);
      exp = exp_q.pop_front();
      bump_cnt();
      checks++;
      if (!found || data !== exp || !shape_ok || !done_ok) begin
        errors++;
        $display("FAIL b2b_frame%0d: found=%0d data=%h shape=%0d done=%0d, want 1 %h 1 1",
                 f, found, data, shape_ok, done_ok, exp);
      end
      if (f > 0) begin
        checks++;
        if (gap != 3) begin
          errors++;
          $display("FAIL b2b_gap%0d: %0d idle-high cycles between frames, want 3", f, gap);
        end
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rd_pulses - rd0 != 3 || underflow != 0 || o_tx_cnt !== CNT_W'(exp_cnt) || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counts: rd_pulses=%0d underflow=%0d cnt=%0d busy=%b, want 3 0 %0d 0",
               rd_pulses - rd0, underflow, o_tx_cnt, o_busy, exp_cnt);
    end
  endtask

  task automatic test_enable_gating();
    int rd0, gap;
    bit found, shape_ok, done_ok;
    logic [7:0] data, exp;
    logic par;
    rd0 = rd_pulses;
    i_tx_en = 1'b0;
    push_byte(8'h5A);
    push_byte(8'hC3);
    repeat (100) @(negedge clk);
    checks++;
    if (rd_pulses != rd0 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
      errors++;
      $display("FAIL enable_hold: rd_pulses=%0d busy=%b tx=%b with enable low, want 0 0 1",
               rd_pulses - rd0, o_busy, o_tx);
    end
    i_tx_en = 1'b1;
    grab_frame(18, found, data, par, shape_ok, done_ok, gap);
    exp = exp_q.pop_front();
    bump_cnt();
    checks++;
    if (!found || data !== exp || !shape_ok || !done_ok) begin
      errors++;
      $display("FAIL enable_drop_frame: found=%0d data=%h shape=%0d done=%0d, want 1 %h 1 1",
               found, data, shape_ok, done_ok, exp);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (rd_pulses - rd0 != 1 || o_busy !== 1'b0 || o_tx_cnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL enable_drop_idle: rd_pulses=%0d busy=%b cnt=%0d, want 1 0 %0d",
               rd_pulses - rd0, o_busy, o_tx_cnt, exp_cnt);
    end
    i_tx_en = 1'b1;
    grab_frame(-1, found, data, par, shape_ok, done_ok, gap);
    exp = exp_q.pop_front();
    bump_cnt();
    checks++;
    if (!found || data !== exp || rd_pulses - rd0 != 2) begin
      errors++;
      $display("FAIL enable_resume: found=%0d data=%h rd_pulses=%0d, want 1 %h 2",
               found, data, rd_pulses - rd0, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rd0;
    bit found;
    logic [7:0] discarded;
    push_byte(8'h86);
    rd0 = rd_pulses;
    found = 0;
    for (int n = 0; n < TIMEOUT && !found; n++) begin
      @(negedge clk);
      if (o_tx === 1'b0) found = 1;
    end
    repeat (21) @(negedge clk);
    checks++;
    if (!found || o_tx !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_bit4: found=%0d tx=%b busy=%b in data bit 4 of 86, want 1 0 1", found, o_tx, o_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_tx_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_async: tx=%b busy=%b rd_en=%b cnt=%0d right after reset, want 1 0 0 0",
               o_tx, o_busy, o_rd_en, o_tx_cnt);
    end
    discarded = exp_q.pop_front();
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_tx !== 1'b1 || o_tx_cnt !== '0 || rd_pulses - rd0 != 1 || underflow != 0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b tx=%b cnt=%0d rd_pulses=%0d underflow=%0d (byte %h dropped), want 0 1 0 1 0",
               o_busy, o_tx, o_tx_cnt, rd_pulses - rd0, underflow, discarded);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int gap;
    bit found, shape_ok, done_ok;
    logic [7:0] data, exp;
    logic par;
    push_byte(8'h07);
    push_byte(8'h03);
    for (int f = 0; f < 2; f++) begin
      grab_frame(-1, found, data, par, shape_ok, done_ok, gap);
      exp = exp_q.pop_front();
      bump_cnt();
      checks++;
      if (!found || data !== exp || par !== ^exp || !shape_ok || !done_ok) begin
        errors++;
        $display("FAIL parity_frame%0d: found=%0d data=%h par=%b shape=%0d done=%0d, want 1 %h %b 1 1",
                 f, found, data, par, shape_ok, done_ok, exp, ^exp);
      end
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL parity_length: busy=%b one cycle after a 44-cycle frame, want 0", o_busy);
    end
  endtask

  task automatic test_wrap();
    int gap;
    bit found, shape_ok, done_ok;
    logic [7:0] data, exp;
    logic par;
    push_byte(8'h11);
    push_byte(8'hE8);
    push_byte(8'h7F);
    for (int f = 0; f < 3; f++) begin
      grab_frame(-1, found, data, par, shape_ok, done_ok, gap);
      exp = exp_q.pop_front();
      bump_cnt();
      checks++;
      if (!found || data !== exp || par !== ^exp) begin
        errors++;
        $display("FAIL wrap_frame%0d: found=%0d data=%h par=%b, want 1 %h %b", f, found, data, par, exp, ^exp);
      end
    end
    checks++;
    if (o_tx_cnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL wrap_count: cnt=%0d after 5 bytes, want %0d", o_tx_cnt, exp_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
    test_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
